mem_lsu_ctrl: RTL and testbench

- Memory-stage load/store controller for the pipelined core with data cache.
- Drives the stage's data-cache request/response handshake and formats load data.
- Produces ReadData_m, valid_m and a stall to the MEM/WB register, whose enable is the inverse of the stall.
- Holds the EX/MEM register via stall while an access is in flight.

---
 rtl/mem_lsu_pkg.sv | 53 +++++
 rtl/load_align.sv | 44 ++++
 rtl/mem_lsu_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_lsu_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types, funct3 codes and helpers for the memory-stage LSU
//
// Purpose: FSM state type, load/store funct3 encodings, and small helpers for
//          the misalignment check and store lane formatting (byte enables and
//          replicated write data).
// Ports:   none (package).

package mem_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store encodings alias the signed load encodings, so one check covers both.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return (off != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << off;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Data is replicated across lanes so the cache only needs the byte enables.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data extraction and extension
//
// Purpose: picks the addressed byte/halfword out of a raw cache word and
//          sign- or zero-extends it according to funct3.
// Ports:   rdata    in  32  raw word from the cache
//          offset   in  2   byte offset within the word
//          funct3   in  3   load size/sign
//          ReadData out 32  formatted load result (0 for unknown funct3)

module load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword loads are only issued when aligned, so offset[1] picks the half.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    ReadData = '0;
    case (funct3)
      F3_LB:   ReadData = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ReadData = {24'b0, byte_sel};
      F3_LH:   ReadData = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ReadData = {16'b0, half_sel};
      F3_LW:   ReadData = rdata;
      default: ReadData = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// rtl/mem_lsu_ctrl.sv - memory-stage load/store controller with cache handshake
//
// Purpose: turns the EX/MEM instruction into a single data-cache request,
//          waits for the response, formats load data and stalls the pipe
//          while the access is in flight. Flushed accesses that already
//          reached the cache are drained so the response is not mistaken for
//          a later instruction's.
// Ports:   clk, rst                 clock, synchronous active-high reset
//          flush                    kill the current memory-stage instruction
//          valid_x, MemRead_x, MemWrite_x, funct3_x, ALUResult_x, WriteData_x
//                                   instruction from the EX/MEM register
//          req_valid/req_ready      cache request handshake
//          req_we, req_addr, req_wdata, req_be
//                                   registered request fields
//          resp_valid, resp_rdata   cache response / write ack
//          valid_m, ReadData_m, misalign_m
//                                   completion to MEM/WB
//          stall_m                  hold EX/MEM; MEM/WB enable is ~stall_m

module mem_lsu_ctrl
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_x,
  input  logic                  MemRead_x,
  input  logic                  MemWrite_x,
  input  logic [2:0]            funct3_x,
  input  logic [DATA_WIDTH-1:0] ALUResult_x,
  input  logic [DATA_WIDTH-1:0] WriteData_x,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [DATA_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [BE_WIDTH-1:0]   req_be,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  valid_m,
  output logic [DATA_WIDTH-1:0] ReadData_m,
  output logic                  misalign_m,
  output logic                  stall_m
);

  lsu_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic                  flush_seen_q;

  logic                  is_mem;
  logic                  misaligned;
  logic                  start;
  logic                  done;
  logic [DATA_WIDTH-1:0] load_data;

  assign is_mem     = MemRead_x | MemWrite_x;
  assign misaligned = is_misaligned(funct3_x, ALUResult_x[1:0]);
  assign start      = (state == S_IDLE) & valid_x & is_mem & ~misaligned & ~flush;

  always_comb begin
    state_nxt  = state;
    req_valid  = 1'b0;
    stall_m    = 1'b0;
    valid_m    = 1'b0;
    misalign_m = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_x & ~flush) begin
          if (~is_mem) begin
            valid_m = 1'b1;
          end else if (misaligned) begin
            // Completes with an exception flag and never touches the cache.
            valid_m    = 1'b1;
            misalign_m = 1'b1;
          end else begin
            stall_m   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        stall_m   = 1'b1;
        // A flush cannot withdraw the request; it only redirects the response.
        if (req_ready) state_nxt = (flush | flush_seen_q) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_m = ~resp_valid;
        if (resp_valid) begin
          state_nxt = S_IDLE;
          if (~flush) begin
            valid_m = 1'b1;
            done    = 1'b1;
          end
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_m = 1'b1;
        if (resp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q  <= {ALUResult_x[DATA_WIDTH-1:2], 2'b00};
        off_q   <= ALUResult_x[1:0];
        f3_q    <= funct3_x;
        we_q    <= MemWrite_x;
        be_q    <= MemWrite_x ? store_be(funct3_x, ALUResult_x[1:0]) : '0;
        wdata_q <= MemWrite_x ? store_wdata(funct3_x, WriteData_x) : '0;
      end
      if (state == S_REQ) flush_seen_q <= (flush_seen_q | flush) & ~req_ready;
      else                flush_seen_q <= 1'b0;
    end
  end

  assign req_we    = we_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_be    = be_q;

  load_align u_load_align (
    .rdata    (resp_rdata),
    .offset   (off_q),
    .funct3   (f3_q),
    .ReadData (load_data)
  );

  assign ReadData_m = (done & ~we_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb/tb_mem_lsu_ctrl.sv - scoreboard bench for mem_lsu_ctrl with a cache model

module tb_mem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, valid_x, MemRead_x, MemWrite_x;
  logic [2:0]  funct3_x;
  logic [31:0] ALUResult_x, WriteData_x;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        valid_m, misalign_m, stall_m;
  logic [31:0] ReadData_m;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_x(valid_x),
    .MemRead_x(MemRead_x), .MemWrite_x(MemWrite_x), .funct3_x(funct3_x),
    .ALUResult_x(ALUResult_x), .WriteData_x(WriteData_x),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .valid_m(valid_m), .ReadData_m(ReadData_m), .misalign_m(misalign_m),
    .stall_m(stall_m)
  );

  typedef struct { logic mis; logic [31:0] data; } comp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  comp_t       exp_q[$];
  req_t        req_q[$];
  logic [31:0] mem [64];
  int          checks = 0;
  int          failures = 0;
  int          ready_pct = 100;
  int          resp_min = 0;
  int          resp_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  // Reference load result from the raw word, by arithmetic on byte values.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] s, b, h;
    s = w >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'd0;
    endcase
  endfunction

  // Cache model: random ready, one outstanding access, random response delay.
  initial begin
    int          cnt;
    logic        pend, prev_wait;
    logic [31:0] rword;
    pend = 1'b0; prev_wait = 1'b0; cnt = 0; rword = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          resp_valid = 1'b1; resp_rdata = rword; pend = 1'b0;
        end else cnt--;
      end
      req_ready = ($urandom_range(0, 99) < ready_pct);
      #2;
      if (rst) begin
        pend = 1'b0; prev_wait = 1'b0;
      end else begin
        if (prev_wait) chk("req_valid_held", {31'b0, req_valid}, 32'd1);
        if (req_valid) begin
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_unexpected: req_valid=1 required 0 (no request outstanding)");
          end else begin
            chk("req_addr",  req_addr,  req_q[0].addr);
            chk("req_we",    {31'b0, req_we}, {31'b0, req_q[0].we});
            chk("req_be",    {28'b0, req_be}, {28'b0, req_q[0].be});
            chk("req_wdata", req_wdata, req_q[0].wdata);
            if (req_ready) begin
              chk("one_outstanding", {31'b0, pend}, 32'd0);
              if (req_q[0].we) begin
                for (int b = 0; b < 4; b++)
                  if (req_q[0].be[b]) mem[midx(req_q[0].addr)][8*b +: 8] = req_q[0].wdata[8*b +: 8];
                rword = $urandom;
              end else begin
                rword = mem[midx(req_q[0].addr)];
              end
              pend = 1'b1;
              cnt  = $urandom_range(resp_min, resp_max);
              void'(req_q.pop_front());
            end
          end
        end
        prev_wait = req_valid && !req_ready;
      end
    end
  end

  // Completion monitor.
  initial begin
    comp_t c;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (valid_m) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL valid_m_unexpected: valid_m=1 required 0");
          end else begin
            c = exp_q.pop_front();
            chk("misalign_m", {31'b0, misalign_m}, {31'b0, c.mis});
            chk("ReadData_m", ReadData_m, c.data);
          end
        end else begin
          chk("idle_outputs", {ReadData_m[30:0], misalign_m}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    valid_x = 1'b0; MemRead_x = 1'b0; MemWrite_x = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #2;
    while (stall_m && n < 200) begin
      @(negedge clk); #2; n++;
    end
    if (stall_m) begin
      checks++; failures++;
      $display("FAIL drain_timeout: stall_m=1 after %0d cycles, required 0", n);
    end
    @(negedge clk);
  endtask

  // Presents one instruction (called at a negedge) and returns once it leaves MEM.
  task automatic run_instr(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int flush_at,
                           output int stalls);
    logic        pushed, mis;
    int          off, cyc, bei;
    logic [31:0] wexp;
    comp_t       c;
    req_t        r;
    pushed = 1'b0; stalls = 0; off = int'(a % 4);
    if (v) begin
      if (!(rd || wr)) begin
        c.mis = 1'b0; c.data = '0; exp_q.push_back(c); pushed = 1'b1;
      end else begin
        mis = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
        if (mis) begin
          c.mis = 1'b1; c.data = '0;
        end else begin
          if (wr) begin
            bei  = (f3 == 3'd0) ? (1 << off) : (f3 == 3'd1) ? (3 << off) : 15;
            wexp = (f3 == 3'd0) ? (wd % 256) * 32'h0101_0101 :
                   (f3 == 3'd1) ? (wd % 65536) * 32'h0001_0001 : wd;
          end else begin
            bei = 0; wexp = '0;
          end
          r.addr = a - (a % 4); r.we = wr; r.be = 4'(bei); r.wdata = wexp;
          if (flush_at != 0) req_q.push_back(r);
          c.mis = 1'b0; c.data = wr ? 32'd0 : fmt_load(mem[midx(a)], off, f3);
        end
        exp_q.push_back(c); pushed = 1'b1;
      end
    end
    valid_x = v; MemRead_x = rd; MemWrite_x = wr; funct3_x = f3;
    ALUResult_x = a; WriteData_x = wd;
    cyc = 0;
    forever begin
      if (cyc == flush_at) begin
        flush = 1'b1;
        if (pushed) void'(exp_q.pop_back());
        @(negedge clk);
        flush = 1'b0; idle_inputs();
        wait_idle();
        return;
      end
      #2;
      if (!stall_m) begin
        @(negedge clk); idle_inputs();
        return;
      end
      stalls++;
      if (stalls > 200) begin
        checks++; failures++;
        $display("FAIL stall_timeout: stall_m=1 for %0d cycles, required completion", stalls);
        @(negedge clk); idle_inputs();
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int st, kind, fa;
    logic [2:0] f3;
    rst = 1'b1; flush = 1'b0; idle_inputs(); funct3_x = '0; ALUResult_x = '0; WriteData_x = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_we",    {31'b0, req_we}, 32'd0);
    chk("rst_req_be",    {28'b0, req_be}, 32'd0);
    chk("rst_req_addr",  req_addr, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_valid_m",   {31'b0, valid_m}, 32'd0);
    chk("rst_misalign",  {31'b0, misalign_m}, 32'd0);
    chk("rst_stall_m",   {31'b0, stall_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Minimum latency load, then the formatting examples.
    mem[midx(32'h100)] = 32'hDEAD_BEEF;
    run_instr(1, 1, 0, 3'd2, 32'h100, 0, -1, st);
    chk("lw_min_latency_stalls", st, 32'd2);
    mem[midx(32'h100)] = 32'h80FF_FF7F;
    run_instr(1, 1, 0, 3'd0, 32'h103, 0, -1, st);
    run_instr(1, 1, 0, 3'd4, 32'h103, 0, -1, st);
    run_instr(1, 1, 0, 3'd5, 32'h102, 0, -1, st);
    run_instr(1, 0, 1, 3'd1, 32'h202, 32'h1234_ABCD, -1, st);

    // Request held off by the cache for several cycles.
    ready_pct = 0;
    fork begin repeat (4) @(negedge clk); ready_pct = 100; end join_none
    run_instr(1, 1, 0, 3'd2, 32'h104, 0, -1, st);

    // Flush while waiting, response two cycles after handshake, then next op.
    resp_min = 2; resp_max = 2;
    run_instr(1, 1, 0, 3'd2, 32'h108, 0, 2, st);
    resp_min = 0; resp_max = 0;
    run_instr(1, 1, 0, 3'd2, 32'h10C, 0, -1, st);

    // Misaligned word completes immediately without a request.
    run_instr(1, 1, 0, 3'd2, 32'h101, 0, -1, st);
    chk("misaligned_no_stall", st, 32'd0);

    // Reset while the request is pending.
    ready_pct = 0;
    req_q.push_back('{addr: 32'h100, we: 1'b0, be: 4'b0, wdata: 32'd0});
    valid_x = 1'b1; MemRead_x = 1'b1; funct3_x = 3'd2; ALUResult_x = 32'h100;
    #2 chk("req_c0_stall", {31'b0, stall_m}, 32'd1);
    @(negedge clk); idle_inputs();
    #2 chk("req_pending", {31'b0, req_valid}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req_q.delete();
    #2;
    chk("rst_mid_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_mid_stall",     {31'b0, stall_m}, 32'd0);
    chk("rst_mid_addr",      req_addr, 32'd0);
    chk("rst_mid_be_we",     {27'b0, req_be, req_we}, 32'd0);
    @(negedge clk);
    ready_pct = 100;

    // Randomised mix of bubbles, ALU ops, loads, stores and flushes.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0: ready_pct = 100;
        1: ready_pct = 60;
        default: ready_pct = 30;
      endcase
      resp_min = 0; resp_max = $urandom_range(0, 3);
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
      kind = $urandom_range(0, 19);
      if (kind < 2)       run_instr(0, 0, 0, 3'd0, $urandom, $urandom, fa, st);
      else if (kind < 6)  run_instr(1, 0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, fa, st);
      else if (kind < 13) run_instr(1, 1, 0, 3'($urandom_range(0, 7)),
                                    32'h100 + $urandom_range(0, 255), 0, fa, st);
      else begin
        f3 = 3'($urandom_range(0, 2));
        run_instr(1, 0, 1, f3, 32'h100 + $urandom_range(0, 255), $urandom, fa, st);
      end
    end

    repeat (5) @(negedge clk);
    chk("completions_drained", 32'(exp_q.size()), 32'd0);
    chk("requests_drained",    32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
